// File: rtl/event_enable_gen.sv
// rtl/event_enable_gen.sv - synchronized, optionally debounced event line to one-cycle count enables
// Build option: define EVENT_DEBOUNCE_EN to include the debounce FSM and glitch counter.
module event_enable_gen #(
    parameter int sync_stages     = 2,
    parameter int debounce_cycles = 16,
    parameter int glitch_width    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    evt_in,
    input  logic [1:0]              edge_sel,
    output logic                    pulse_out,
    output logic                    level_out,
    output logic [glitch_width-1:0] glitch_cnt
);

    if (sync_stages < 2 || debounce_cycles < 1) begin : g_param_check
        $error("event_enable_gen: sync_stages must be >= 2 and debounce_cycles >= 1");
    end

    logic [sync_stages-1:0] r_sync;
    logic                   w_s;
    logic                   r_lvl;
    logic                   r_lvl_d;
    logic                   r_pulse;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_sel_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[sync_stages-2:0], evt_in};
        end
    end

    assign w_s = r_sync[sync_stages-1];

`ifdef EVENT_DEBOUNCE_EN
    localparam int CNT_W = $clog2(debounce_cycles + 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_lvl_nxt;
    logic                    w_glitch_hit;
    logic [glitch_width-1:0] r_glitch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_lvl   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lvl   <= w_lvl_nxt;
        end
    end

    // A sample matching lvl while settling is a glitch, even on the cycle the count would complete.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_lvl_nxt    = r_lvl;
        w_glitch_hit = 1'b0;
        case (r_state)
            ST_STABLE: begin
                if (w_s != r_lvl) begin
                    if (debounce_cycles == 1) begin
                        w_lvl_nxt = ~r_lvl;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = ST_SETTLING;
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            ST_SETTLING: begin
                if (w_s == r_lvl) begin
                    w_glitch_hit = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = ST_STABLE;
                end else if (r_cnt == CNT_W'(debounce_cycles - 1)) begin
                    w_lvl_nxt   = ~r_lvl;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_STABLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_STABLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_glitch <= '0;
        end else if (w_glitch_hit && (r_glitch != {glitch_width{1'b1}})) begin
            r_glitch <= r_glitch + 1'b1;
        end
    end

    assign glitch_cnt = r_glitch;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lvl <= 1'b0;
        end else begin
            r_lvl <= w_s;
        end
    end

    assign glitch_cnt = '0;
`endif

    assign w_rise = r_lvl & ~r_lvl_d;
    assign w_fall = ~r_lvl & r_lvl_d;

    always_comb begin
        w_sel_edge = 1'b0;
        case (edge_sel)
            2'b00:   w_sel_edge = w_rise;
            2'b01:   w_sel_edge = w_fall;
            2'b10:   w_sel_edge = w_rise | w_fall;
            default: w_sel_edge = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lvl_d <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_lvl_d <= r_lvl;
            r_pulse <= en & w_sel_edge;
        end
    end

    assign pulse_out = r_pulse;
    assign level_out = r_lvl;

endmodule

// File: tb/tb_event_enable_gen.sv
// tb/tb_event_enable_gen.sv - directed table-driven bench for event_enable_gen
module tb_event_enable_gen;

`ifdef EVENT_DEBOUNCE_EN
    localparam int L        = 18;
    localparam int GL_ONE   = 1;
    localparam int GL_SAT   = 255;
    localparam int GL_PULSE = 0;
`else
    localparam int L        = 3;
    localparam int GL_ONE   = 0;
    localparam int GL_SAT   = 0;
    localparam int GL_PULSE = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       evt_in;
    logic [1:0] edge_sel;
    logic       pulse_out;
    logic       level_out;
    logic [7:0] glitch_cnt;

    int checks   = 0;
    int failures = 0;
    int pulse_cnt = 0;
    int wide_cnt  = 0;
    logic prev_pulse = 1'b0;

    typedef struct {
        logic       evt;
        logic       en;
        logic [1:0] sel;
        int         n;
        logic       exp_lvl;
        logic       exp_pulse;
    } vec_t;

    vec_t tbl[$];

    event_enable_gen #(.sync_stages(2), .debounce_cycles(16), .glitch_width(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .evt_in     (evt_in),
        .edge_sel   (edge_sel),
        .pulse_out  (pulse_out),
        .level_out  (level_out),
        .glitch_cnt (glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pulse_out) pulse_cnt <= pulse_cnt + 1;
        if (pulse_out && prev_pulse) wide_cnt <= wide_cnt + 1;
        prev_pulse <= pulse_out;
    end

    function automatic vec_t mk(logic e, logic g, logic [1:0] s, int n, logic l, logic p);
        vec_t v;
        v.evt = e; v.en = g; v.sel = s; v.n = n; v.exp_lvl = l; v.exp_pulse = p;
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(vec_t v, string tag);
        evt_in   = v.evt;
        en       = v.en;
        edge_sel = v.sel;
        repeat (v.n) @(posedge clk);
        @(negedge clk);
        check({tag, ".level"}, int'(level_out), int'(v.exp_lvl));
        check({tag, ".pulse"}, int'(pulse_out), int'(v.exp_pulse));
    endtask

    task automatic hold(logic e, int n);
        evt_in = e;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    int c0;

    initial begin
        rst_n = 1'b0; en = 1'b1; evt_in = 1'b1; edge_sel = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.pulse", int'(pulse_out), 0);
        check("reset.level", int'(level_out), 0);
        check("reset.glitch", int'(glitch_cnt), 0);
        rst_n = 1'b1;

        // release with evt_in high: level flips at edge L, pulse on edge L+1 only
        tbl.push_back(mk(1, 1, 2'b00, L - 1, 0, 0));
        tbl.push_back(mk(1, 1, 2'b00, 1,     1, 0));
        tbl.push_back(mk(1, 1, 2'b00, 1,     1, 1));
        tbl.push_back(mk(1, 1, 2'b00, 1,     1, 0));
        // falling edge while rising selected
        tbl.push_back(mk(0, 1, 2'b00, L - 1, 1, 0));
        tbl.push_back(mk(0, 1, 2'b00, 1,     0, 0));
        tbl.push_back(mk(0, 1, 2'b00, 1,     0, 0));
        tbl.push_back(mk(0, 1, 2'b00, 2,     0, 0));
        // falling-only mode
        tbl.push_back(mk(1, 1, 2'b01, L + 1, 1, 0));
        tbl.push_back(mk(1, 1, 2'b01, 2,     1, 0));
        tbl.push_back(mk(0, 1, 2'b01, L,     0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 1,     0, 1));
        tbl.push_back(mk(0, 1, 2'b01, 1,     0, 0));
        // no-edge mode
        tbl.push_back(mk(1, 1, 2'b11, L + 1, 1, 0));
        tbl.push_back(mk(1, 1, 2'b11, 2,     1, 0));
        // en low during an accepted edge: level tracks, pulse lost
        tbl.push_back(mk(0, 0, 2'b10, L,     0, 0));
        tbl.push_back(mk(0, 0, 2'b10, 1,     0, 0));
        tbl.push_back(mk(0, 0, 2'b10, 2,     0, 0));
        tbl.push_back(mk(1, 1, 2'b10, L,     1, 0));
        tbl.push_back(mk(1, 1, 2'b10, 1,     1, 1));
        tbl.push_back(mk(1, 1, 2'b10, 1,     1, 0));
        tbl.push_back(mk(0, 1, 2'b00, L + 3, 0, 0));

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // short high burst: rejected by the debouncer, passed straight through otherwise
        en = 1'b1; edge_sel = 2'b00;
        c0 = pulse_cnt;
        hold(1'b1, 10);
        hold(1'b0, 25);
        check("glitch.pulses", pulse_cnt - c0, GL_PULSE);
        check("glitch.level", int'(level_out), 0);
        check("glitch.count1", int'(glitch_cnt), GL_ONE);
        for (int i = 0; i < 299; i++) begin
            hold(1'b1, 10);
            hold(1'b0, 20);
        end
        check("glitch.saturated", int'(glitch_cnt), GL_SAT);
        check("glitch.level_after", int'(level_out), 0);

        // both-edges mode, six toggles
        edge_sel = 2'b10;
        c0 = pulse_cnt;
        for (int i = 0; i < 6; i++) hold(~evt_in, 40);
        hold(evt_in, 5);
        check("both.pulses", pulse_cnt - c0, 6);
        check("both.level", int'(level_out), 0);
        check("pulse.width", wide_cnt, 0);

        // async reset while settling towards a low level
        edge_sel = 2'b00;
        run_vec(mk(1, 1, 2'b00, L + 2, 1, 0), "pre_rst");
        evt_in = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.level", int'(level_out), 0);
        check("midrst.pulse", int'(pulse_out), 0);
        check("midrst.glitch", int'(glitch_cnt), 0);
`ifdef EVENT_DEBOUNCE_EN
        check("midrst.cnt", int'(dut.r_cnt), 0);
        check("midrst.state", int'(dut.r_state), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk(1, 1, 2'b00, L - 1, 0, 0), "post_rst0");
        run_vec(mk(1, 1, 2'b00, 1,     1, 0), "post_rst1");
        run_vec(mk(1, 1, 2'b00, 1,     1, 1), "post_rst2");
        run_vec(mk(1, 1, 2'b00, 1,     1, 0), "post_rst3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
